effects_sequencer: RTL
======================

EFFECTS_SEQUENCER -- requirements
Module: effects_sequencer

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, 16, sample width; N_EFFECTS, 4, number of effect slots; TIMEOUT, 255, maximum WAIT cycles per effect.
REQ-002 clk  in  1  single system clock; all logic on rising edge.
REQ-003 rst  in  1  reset; synchronous, active-high.
REQ-004 sample_valid  in  1  one-cycle pulse; sample_in is valid.
REQ-005 sample_in  in  DATA_WIDTH  signed input sample.
REQ-006 effect_enable  in  N_EFFECTS  per-slot enable; bit i = 0 bypasses slot i.
REQ-007 effect_done  in  N_EFFECTS  per-slot completion strobe from each effect.
REQ-008 effect_data_out  in  N_EFFECTS*DATA_WIDTH  flattened effect results; slot i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-009 effect_turn  out  N_EFFECTS  one-hot-or-zero turn grant, registered.
REQ-010 effect_cs  out  N_EFFECTS  per-slot enable snapshot for the current pass, registered.
REQ-011 effect_data_in  out  DATA_WIDTH  shared working sample bus to all effects.
REQ-012 sample_out / sample_out_valid  out  DATA_WIDTH / 1  processed sample and its one-cycle valid pulse.
REQ-013 busy  out  1  high in every state except IDLE.
REQ-014 overrun / timeout_err  out  1 / 1  sticky error flags.
REQ-015 clear_flags  in  1  clears both sticky flags.

Function
REQ-016 FSM states SHALL be IDLE, SELECT, WAIT, OUTPUT.
REQ-017 IDLE: on sample_valid, latch sample_in into work register, latch effect_enable into effect_cs, idx=0, go SELECT.
REQ-018 SELECT: idx==N_EFFECTS -> OUTPUT; else effect_cs[idx]=1 -> WAIT with effect_turn[idx]=1 on entry; else idx+1, stay SELECT (1 cycle per bypassed slot).
REQ-019 WAIT: effect_turn[idx] held high until effect_done[idx] is sampled high; on that edge capture effect_data_out slot idx into work register, clear effect_turn, idx+1, go SELECT.
REQ-020 WAIT watchdog counts WAIT cycles from 0; on the edge it reaches TIMEOUT without done: clear effect_turn, keep work register unchanged, set timeout_err, idx+1, go SELECT.
REQ-021 Done and timeout in the same cycle SHALL be treated as done.
REQ-022 effect_done bits of non-granted slots SHALL be ignored.
REQ-023 effect_data_in SHALL equal the work register at all times.
REQ-024 OUTPUT: sample_out = work register, sample_out_valid high for exactly this one cycle, go IDLE; sample_out holds its value until next OUTPUT.
REQ-025 sample_valid in any state other than IDLE (including OUTPUT) SHALL drop that sample and set overrun.
REQ-026 effect_enable changes during a pass SHALL NOT affect that pass.
REQ-027 Latency, sample_valid cycle to sample_out_valid cycle, SHALL be 1 + (N_EFFECTS+1) + sum of WAIT cycles; a one-cycle responder costs 2 WAIT cycles.
REQ-028 clear_flags SHALL clear the flags on the next edge; a set event in the same cycle wins.
REQ-029 Data SHALL pass unmodified; no arithmetic, saturation or width change in this block.

Reset
REQ-030 rst SHALL force state IDLE, idx 0, watchdog 0, work register 0, and all outputs 0 on the next edge.
REQ-031 rst mid-pass SHALL drop effect_turn on the next edge, discard the in-flight sample, and emit no sample_out_valid.

Structure
REQ-032 A shared package SHALL hold the state encoding and the DATA_WIDTH / N_EFFECTS / TIMEOUT defaults, for reuse by effect modules.
REQ-033 The watchdog SHALL be one sub-module, turn_watchdog, with clear, enable and expired ports.

Verification
REQ-034 N=4, all enabled, one-cycle responders adding +1, sample_in=100 -> sample_out=104, valid exactly 14 cycles after sample_valid.
REQ-035 effect_enable=0000, sample_in=-5 -> sample_out=-5 after 6 cycles, effect_turn never asserted.
REQ-036 Slot 2 never asserts done, TIMEOUT=8 -> turn[2] high 8 cycles then drops, timeout_err=1, slot 2 bypassed, pass completes.
REQ-037 sample_valid pulsed during WAIT and again during OUTPUT -> both dropped, overrun=1, only first sample output; clear_flags -> overrun=0.
REQ-038 rst asserted in WAIT of slot 1 -> next cycle all outputs 0, state IDLE, no sample_out_valid; next sample processes normally.
REQ-039 effect_enable toggled mid-pass -> effect_cs constant through pass; new mask applies to next sample.

Source files
------------

// File: rtl/effects_sequencer_pkg.sv
// rtl/effects_sequencer_pkg.sv - shared state encoding and default sizes for the effects sequencer family
package effects_sequencer_pkg;

    localparam int DATA_WIDTH_DEFAULT = 16;
    localparam int N_EFFECTS_DEFAULT  = 4;
    localparam int TIMEOUT_DEFAULT    = 255;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SELECT = 2'd1,
        ST_WAIT   = 2'd2,
        ST_OUTPUT = 2'd3
    } seq_state_e;

endpackage

// File: rtl/effects_sequencer_if.sv
// rtl/effects_sequencer_if.sv - sample and effect-slot bus between the sequencer and its environment
interface effects_sequencer_if
    import effects_sequencer_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
    parameter int N_EFFECTS  = N_EFFECTS_DEFAULT
) ();

    logic                            sample_valid;
    logic [DATA_WIDTH-1:0]           sample_in;
    logic [N_EFFECTS-1:0]            effect_enable;
    logic [N_EFFECTS-1:0]            effect_done;
    logic [N_EFFECTS*DATA_WIDTH-1:0] effect_data_out;
    logic                            clear_flags;

    logic [N_EFFECTS-1:0]            effect_turn;
    logic [N_EFFECTS-1:0]            effect_cs;
    logic [DATA_WIDTH-1:0]           effect_data_in;
    logic [DATA_WIDTH-1:0]           sample_out;
    logic                            sample_out_valid;
    logic                            busy;
    logic                            overrun;
    logic                            timeout_err;

    // Sequencer side
    modport slave (
        input  sample_valid, sample_in, effect_enable, effect_done, effect_data_out, clear_flags,
        output effect_turn, effect_cs, effect_data_in, sample_out, sample_out_valid,
               busy, overrun, timeout_err
    );

    // Environment side: sample source, effect slots and status reader
    modport master (
        output sample_valid, sample_in, effect_enable, effect_done, effect_data_out, clear_flags,
        input  effect_turn, effect_cs, effect_data_in, sample_out, sample_out_valid,
               busy, overrun, timeout_err
    );

endinterface

// File: rtl/effects_sequencer_turn_watchdog.sv
// rtl/effects_sequencer_turn_watchdog.sv - per-turn cycle counter that flags an unresponsive effect slot
module turn_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] count_q, count_d;

    // The TIMEOUT-th enabled cycle is the expiring one, so the grant lasts exactly TIMEOUT cycles
    assign expired = enable && (count_q == CW'(TIMEOUT - 1));

    // Count enabled cycles, restart whenever the turn is not active
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && !expired) begin
            count_d = count_q + 1'b1;
        end
    end

    // Counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/effects_sequencer.sv
// rtl/effects_sequencer.sv - walks one sample through the enabled effect slots in index order
module effects_sequencer
    import effects_sequencer_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
    parameter int N_EFFECTS  = N_EFFECTS_DEFAULT,
    parameter int TIMEOUT    = TIMEOUT_DEFAULT
) (
    input logic          clk,
    input logic          rst,
    effects_sequencer_if.slave bus
);

    localparam int IDX_W  = $clog2(N_EFFECTS + 1);
    localparam int SLOT_W = (N_EFFECTS > 1) ? $clog2(N_EFFECTS) : 1;

    seq_state_e            state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [DATA_WIDTH-1:0] work_q, work_d;
    logic [N_EFFECTS-1:0]  turn_q, turn_d;
    logic [N_EFFECTS-1:0]  cs_q, cs_d;
    logic [DATA_WIDTH-1:0] sample_out_q, sample_out_d;
    logic                  sample_out_valid_q, sample_out_valid_d;
    logic                  busy_q, busy_d;
    logic                  overrun_q, overrun_d;
    logic                  timeout_err_q, timeout_err_d;

    logic [SLOT_W-1:0]     slot;
    logic                  wd_expired;
    logic                  timeout_evt;
    logic                  overrun_evt;

    // idx only reaches N_EFFECTS in SELECT, where it is compared before slot is used
    assign slot = idx_q[SLOT_W-1:0];

    turn_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clear   (state_q != ST_WAIT),
        .enable  (state_q == ST_WAIT),
        .expired (wd_expired)
    );

    // Next-state and registered-output computation for the pass sequencer
    always_comb begin
        state_d            = state_q;
        idx_d              = idx_q;
        work_d             = work_q;
        turn_d             = turn_q;
        cs_d               = cs_q;
        sample_out_d       = sample_out_q;
        sample_out_valid_d = 1'b0;
        timeout_evt        = 1'b0;
        overrun_evt        = bus.sample_valid && (state_q != ST_IDLE);

        case (state_q)
            ST_IDLE: begin
                if (bus.sample_valid) begin
                    work_d  = bus.sample_in;
                    cs_d    = bus.effect_enable;
                    idx_d   = '0;
                    state_d = ST_SELECT;
                end
            end
            ST_SELECT: begin
                if (idx_q == IDX_W'(N_EFFECTS)) begin
                    sample_out_d       = work_q;
                    sample_out_valid_d = 1'b1;
                    state_d            = ST_OUTPUT;
                end else if (cs_q[slot]) begin
                    turn_d  = N_EFFECTS'(1) << slot;
                    state_d = ST_WAIT;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_WAIT: begin
                // Done takes priority over a simultaneous expiry
                if (bus.effect_done[slot]) begin
                    work_d  = bus.effect_data_out[int'(slot)*DATA_WIDTH +: DATA_WIDTH];
                    turn_d  = '0;
                    idx_d   = idx_q + 1'b1;
                    state_d = ST_SELECT;
                end else if (wd_expired) begin
                    timeout_evt = 1'b1;
                    turn_d      = '0;
                    idx_d       = idx_q + 1'b1;
                    state_d     = ST_SELECT;
                end
            end
            ST_OUTPUT: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d        = (state_d != ST_IDLE);
        // A set event in the same cycle as clear_flags keeps the flag set
        overrun_d     = (overrun_q && !bus.clear_flags) || overrun_evt;
        timeout_err_d = (timeout_err_q && !bus.clear_flags) || timeout_evt;
    end

    // State, work register and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q            <= ST_IDLE;
            idx_q              <= '0;
            work_q             <= '0;
            turn_q             <= '0;
            cs_q               <= '0;
            sample_out_q       <= '0;
            sample_out_valid_q <= 1'b0;
            busy_q             <= 1'b0;
            overrun_q          <= 1'b0;
            timeout_err_q      <= 1'b0;
        end else begin
            state_q            <= state_d;
            idx_q              <= idx_d;
            work_q             <= work_d;
            turn_q             <= turn_d;
            cs_q               <= cs_d;
            sample_out_q       <= sample_out_d;
            sample_out_valid_q <= sample_out_valid_d;
            busy_q             <= busy_d;
            overrun_q          <= overrun_d;
            timeout_err_q      <= timeout_err_d;
        end
    end

    assign bus.effect_turn      = turn_q;
    assign bus.effect_cs        = cs_q;
    assign bus.effect_data_in   = work_q;
    assign bus.sample_out       = sample_out_q;
    assign bus.sample_out_valid = sample_out_valid_q;
    assign bus.busy             = busy_q;
    assign bus.overrun          = overrun_q;
    assign bus.timeout_err      = timeout_err_q;

endmodule
